// File: rtl/opera_bus_pkg.sv
// Shared definitions for the Opera Wishbone address decoder.
// Latency: none (constants, types and a helper function only).
// Backpressure: not applicable.
package opera_bus_pkg;

  // Region selected by the CPU address
  typedef enum logic [2:0] {
    REG_EXT   = 3'd0,
    REG_MADAM = 3'd1,
    REG_CLIO  = 3'd2,
    REG_SVF   = 3'd3,
    REG_SVF2  = 3'd4
  } region_t;

  // Peripheral windows (inclusive limits)
  localparam logic [31:0] MADAM_BASE  = 32'h0330_0000;
  localparam logic [31:0] MADAM_LIMIT = 32'h0330_FFFF;
  localparam logic [31:0] CLIO_BASE   = 32'h0340_0000;
  localparam logic [31:0] CLIO_LIMIT  = 32'h0340_FFFF;

  // Single-word stub registers answered locally
  localparam logic [31:0] SVF_ADDR_A  = 32'h0320_6100;
  localparam logic [31:0] SVF_ADDR_B  = 32'h0320_6900;
  localparam logic [31:0] SVF2_ADDR   = 32'h0320_02B4;

  // Data returned by the stub registers and by an abandoned external access
  localparam logic [31:0] SVF_DATA     = 32'hBADA_CCE5;
  localparam logic [31:0] SVF2_DATA    = 32'h0000_0000;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_DEAD;

  function automatic logic in_range(input logic [31:0] adr,
                                    input logic [31:0] base,
                                    input logic [31:0] limit);
    return (adr >= base) && (adr <= limit);
  endfunction

endpackage

// File: rtl/opera_addr_decode.sv
// Combinational address-to-region decoder for the Opera CPU bus.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the address every cycle.
module opera_addr_decode
  import opera_bus_pkg::*;
(
  input  logic [31:0] adr,
  output logic [2:0]  region
);

  // Priority order is irrelevant since the windows are disjoint; EXT is the fallback
  always_comb begin
    region = REG_EXT;
    if (in_range(adr, MADAM_BASE, MADAM_LIMIT)) begin
      region = REG_MADAM;
    end else if (in_range(adr, CLIO_BASE, CLIO_LIMIT)) begin
      region = REG_CLIO;
    end else if ((adr == SVF_ADDR_A) || (adr == SVF_ADDR_B)) begin
      region = REG_SVF;
    end else if (adr == SVF2_ADDR) begin
      region = REG_SVF2;
    end
  end

endmodule

// File: rtl/opera_wb_decoder.sv
// Wishbone slave that routes CPU accesses to MADAM, CLIO, SVF stubs or the external bus.
// Latency: 2 cycles (SVF) up to wait+2 (MADAM/CLIO); EXT waits for ext_ack (or timeout).
// Backpressure: wb_ack withheld until data is ready; wb_cyc drop aborts. Option: OPERA_BUS_TIMEOUT_EN.
module opera_wb_decoder
  import opera_bus_pkg::*;
#(
  parameter int MADAM_WAIT     = 1,
  parameter int CLIO_WAIT      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_25m,
  input  logic        reset_n,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_w,
  input  logic [3:0]  wb_sel,
  input  logic        wb_we,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  output logic [31:0] wb_dat_r,
  output logic        wb_ack,
  output logic        madam_rd,
  output logic        madam_wr,
  input  logic [31:0] madam_dout,
  output logic        clio_rd,
  output logic        clio_wr,
  input  logic [31:0] clio_dout,
  output logic        ext_stb,
  output logic        ext_we,
  input  logic        ext_ack,
  input  logic [31:0] ext_dat,
  output logic        bus_err
);

  if ((MADAM_WAIT < 0) || (MADAM_WAIT > 15)) begin : g_bad_madam_wait
    $error("MADAM_WAIT must be 0..15");
  end
  if ((CLIO_WAIT < 0) || (CLIO_WAIT > 15)) begin : g_bad_clio_wait
    $error("CLIO_WAIT must be 0..15");
  end
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be 1..255");
  end

  localparam logic [3:0] MADAM_W = 4'(MADAM_WAIT);
  localparam logic [3:0] CLIO_W  = 4'(CLIO_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXT, S_ACK} state_t;

  state_t      state, state_nxt;
  region_t     region, region_q, region_nxt;
  logic [2:0]  region_raw;
  logic        we_q, we_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic [31:0] rdata_q, rdata_nxt;
  logic        req;

  // Peripherals are word-wide and writes carry no data to MADAM/CLIO here
  logic unused_inputs;
  assign unused_inputs = ^{wb_sel, wb_dat_w};

  opera_addr_decode u_decode (
    .adr    (wb_adr),
    .region (region_raw)
  );
  assign region = region_t'(region_raw);

  // Gated by reset so no strobe leaks out while the block is held in reset
  assign req = wb_cyc & wb_stb & reset_n;

  assign wb_dat_r = rdata_q;

`ifdef OPERA_BUS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt, to_cnt_nxt;
  logic       err_q, err_nxt;

  // Timeout counter and the error flag reported alongside the ack
  always_ff @(posedge clk_25m or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      to_cnt <= to_cnt_nxt;
      err_q  <= err_nxt;
    end
  end
`else
  assign bus_err = 1'b0;
`endif

  // State register plus latched decode, direction, wait count and read data
  always_ff @(posedge clk_25m or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      region_q <= REG_EXT;
      we_q     <= 1'b0;
      wait_cnt <= 4'd0;
      rdata_q  <= 32'd0;
    end else begin
      state    <= state_nxt;
      region_q <= region_nxt;
      we_q     <= we_nxt;
      wait_cnt <= wait_cnt_nxt;
      rdata_q  <= rdata_nxt;
    end
  end

  // Next-state logic and all bus-side outputs
  always_comb begin
    state_nxt    = state;
    region_nxt   = region_q;
    we_nxt       = we_q;
    wait_cnt_nxt = wait_cnt;
    rdata_nxt    = rdata_q;
    wb_ack       = 1'b0;
    madam_rd     = 1'b0;
    madam_wr     = 1'b0;
    clio_rd      = 1'b0;
    clio_wr      = 1'b0;
    ext_stb      = 1'b0;
    ext_we       = 1'b0;
`ifdef OPERA_BUS_TIMEOUT_EN
    to_cnt_nxt   = to_cnt;
    err_nxt      = err_q;
    bus_err      = 1'b0;
`endif

    case (state)
      S_IDLE: begin
`ifdef OPERA_BUS_TIMEOUT_EN
        err_nxt = 1'b0;
`endif
        if (req) begin
          region_nxt = region;
          we_nxt     = wb_we;
          case (region)
            REG_MADAM: begin
              state_nxt    = S_WAIT;
              wait_cnt_nxt = MADAM_W;
              madam_rd     = ~wb_we;
              madam_wr     = wb_we;
            end
            REG_CLIO: begin
              state_nxt    = S_WAIT;
              wait_cnt_nxt = CLIO_W;
              clio_rd      = ~wb_we;
              clio_wr      = wb_we;
            end
            REG_SVF: begin
              state_nxt = S_ACK;
              rdata_nxt = SVF_DATA;
            end
            REG_SVF2: begin
              state_nxt = S_ACK;
              rdata_nxt = SVF2_DATA;
            end
            default: begin
              state_nxt = S_EXT;
`ifdef OPERA_BUS_TIMEOUT_EN
              to_cnt_nxt = 8'd0;
`endif
            end
          endcase
        end
      end

      // A wait of 0 or 1 both spend a single cycle here
      S_WAIT: begin
        if (!wb_cyc) begin
          state_nxt    = S_IDLE;
          wait_cnt_nxt = 4'd0;
        end else if (wait_cnt <= 4'd1) begin
          state_nxt    = S_ACK;
          wait_cnt_nxt = 4'd0;
          rdata_nxt    = (region_q == REG_CLIO) ? clio_dout : madam_dout;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end

      S_EXT: begin
        ext_stb = wb_cyc;
        ext_we  = wb_cyc & we_q;
        if (!wb_cyc) begin
          state_nxt = S_IDLE;
        end else if (ext_ack) begin
          state_nxt = S_ACK;
          rdata_nxt = ext_dat;
`ifdef OPERA_BUS_TIMEOUT_EN
        end else if (to_cnt == TO_LAST) begin
          state_nxt = S_ACK;
          rdata_nxt = TIMEOUT_DATA;
          err_nxt   = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + 8'd1;
`endif
        end
      end

      S_ACK: begin
        wb_ack    = 1'b1;
        state_nxt = S_IDLE;
`ifdef OPERA_BUS_TIMEOUT_EN
        bus_err   = err_q;
`endif
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_opera_wb_decoder.sv
// Scoreboard bench for opera_wb_decoder: directed accesses push expected acks,
// an independent monitor pops and compares on every wb_ack.
module tb_opera_wb_decoder;

  logic        clk_25m = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] wb_adr = 32'd0, wb_dat_w = 32'd0;
  logic [3:0]  wb_sel = 4'hF;
  logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
  logic [31:0] wb_dat_r;
  logic        wb_ack;
  logic        madam_rd, madam_wr, clio_rd, clio_wr;
  logic [31:0] madam_dout = 32'd0, clio_dout = 32'd0;
  logic        ext_stb, ext_we;
  logic        ext_ack = 1'b0;
  logic [31:0] ext_dat = 32'd0;
  logic        bus_err;

  opera_wb_decoder #(
    .MADAM_WAIT     (1),
    .CLIO_WAIT      (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_25m    (clk_25m),
    .reset_n    (reset_n),
    .wb_adr     (wb_adr),
    .wb_dat_w   (wb_dat_w),
    .wb_sel     (wb_sel),
    .wb_we      (wb_we),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_dat_r   (wb_dat_r),
    .wb_ack     (wb_ack),
    .madam_rd   (madam_rd),
    .madam_wr   (madam_wr),
    .madam_dout (madam_dout),
    .clio_rd    (clio_rd),
    .clio_wr    (clio_wr),
    .clio_dout  (clio_dout),
    .ext_stb    (ext_stb),
    .ext_we     (ext_we),
    .ext_ack    (ext_ack),
    .ext_dat    (ext_dat),
    .bus_err    (bus_err)
  );

  always #20 clk_25m = ~clk_25m;

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;

  typedef struct {
    logic [31:0] dat;
    logic        chk_dat;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  // Per-access activity counters, cleared by the driver
  int madam_rd_n = 0, madam_wr_n = 0, clio_rd_n = 0, clio_wr_n = 0;
  int stb_cycles = 0, we_cycles = 0;
  int ext_delay = 0;
  logic ext_auto = 1'b0;
  logic [31:0] ext_resp = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(posedge clk_25m) cyc_no <= cyc_no + 1;

  // External bus responder: acks in the ext_delay-th strobe cycle
  always @(negedge clk_25m) begin
    if (ext_stb) begin
      stb_cycles = stb_cycles + 1;
      if (ext_we) we_cycles = we_cycles + 1;
      if (ext_auto && stb_cycles == ext_delay) begin
        ext_ack = 1'b1;
        ext_dat = ext_resp;
      end else begin
        ext_ack = 1'b0;
      end
    end else begin
      ext_ack = 1'b0;
    end
  end

  // Monitor: pulse bookkeeping and scoreboard comparison on each ack
  exp_t e;
  always @(negedge clk_25m) begin
    madam_rd_n += int'(madam_rd);
    madam_wr_n += int'(madam_wr);
    clio_rd_n  += int'(clio_rd);
    clio_wr_n  += int'(clio_wr);
    check("pulse_onehot", 32'(($countones({madam_rd, madam_wr, clio_rd, clio_wr}) <= 1)), 32'd1);
    if (reset_n && wb_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_cycle", 32'(cyc_no), 32'(e.cyc));
        if (e.chk_dat) check("rd_data", wb_dat_r, e.dat);
        check("bus_err", 32'(bus_err), 32'(e.err));
      end
    end
  end

  task automatic clear_counts();
    madam_rd_n = 0; madam_wr_n = 0; clio_rd_n = 0; clio_wr_n = 0;
    stb_cycles = 0; we_cycles = 0;
  endtask

  // One Wishbone access; lat = posedges from stb assertion to the edge sampling ack
  task automatic access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic chk, input logic [31:0] exp_dat, input int lat,
                        input logic err);
    exp_t x;
    logic got;
    @(posedge clk_25m); #1;
    clear_counts();
    wb_adr = adr; wb_we = we; wb_dat_w = dat; wb_cyc = 1'b1; wb_stb = 1'b1;
    x.dat = exp_dat; x.chk_dat = chk; x.err = err; x.cyc = cyc_no + lat - 1;
    sb.push_back(x);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_25m);
      if (wb_ack) got = 1'b1;
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    @(posedge clk_25m); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic check_pulses(input string tag, input int mr, input int mw, input int cr, input int cw);
    check({tag, "_madam_rd"}, 32'(madam_rd_n), 32'(mr));
    check({tag, "_madam_wr"}, 32'(madam_wr_n), 32'(mw));
    check({tag, "_clio_rd"},  32'(clio_rd_n),  32'(cr));
    check({tag, "_clio_wr"},  32'(clio_wr_n),  32'(cw));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wb_ack"},  32'(wb_ack),  32'd0);
    check({tag, "_pulses"},  32'({madam_rd, madam_wr, clio_rd, clio_wr}), 32'd0);
    check({tag, "_ext_stb"}, 32'(ext_stb), 32'd0);
    check({tag, "_ext_we"},  32'(ext_we),  32'd0);
    check({tag, "_bus_err"}, 32'(bus_err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = 32'h0330_0000;
    #50;
    check_idle_outputs("reset");
    check("reset_dat_r", wb_dat_r, 32'd0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk_25m); reset_n = 1'b1;

    // MADAM read, wait 1
    madam_dout = 32'h1234_5678;
    access(32'h0330_0004, 1'b0, 32'd0, 1'b1, 32'h1234_5678, 3, 1'b0);
    check_pulses("madam_rd", 1, 0, 0, 0);

    // CLIO write, wait 2
    access(32'h0340_0040, 1'b1, 32'hA5A5_0001, 1'b0, 32'd0, 4, 1'b0);
    check_pulses("clio_wr", 0, 0, 0, 1);

    // SVF / SVF2 stubs
    access(32'h0320_6100, 1'b0, 32'd0, 1'b1, 32'hBADA_CCE5, 2, 1'b0);
    check_pulses("svf_a", 0, 0, 0, 0);
    check("svf_a_ext_stb", 32'(stb_cycles), 32'd0);
    access(32'h0320_02B4, 1'b0, 32'd0, 1'b1, 32'h0000_0000, 2, 1'b0);
    check_pulses("svf2", 0, 0, 0, 0);
    access(32'h0320_6900, 1'b0, 32'd0, 1'b1, 32'hBADA_CCE5, 2, 1'b0);
    access(32'h0320_6100, 1'b1, 32'h1111_1111, 1'b0, 32'd0, 2, 1'b0);
    check_pulses("svf_wr", 0, 0, 0, 0);
    check("svf_wr_hold", wb_dat_r, 32'hBADA_CCE5);

    // EXT read, ack in the 5th strobe cycle
    ext_auto = 1'b1; ext_delay = 5; ext_resp = 32'hE1A0_0000;
    access(32'h0000_0100, 1'b0, 32'd0, 1'b1, 32'hE1A0_0000, 7, 1'b0);
    check("ext_rd_stb_cycles", 32'(stb_cycles), 32'd5);
    check("ext_rd_we_cycles",  32'(we_cycles),  32'd0);

    // EXT write, immediate ack
    ext_delay = 1; ext_resp = 32'h0000_0000;
    access(32'h0400_0000, 1'b1, 32'hCAFE_0001, 1'b0, 32'd0, 3, 1'b0);
    check("ext_wr_stb_cycles", 32'(stb_cycles), 32'd1);
    check("ext_wr_we_cycles",  32'(we_cycles),  32'd1);

    // Window edges
    madam_dout = 32'h1111_2222;
    access(32'h0330_FFFF, 1'b0, 32'd0, 1'b1, 32'h1111_2222, 3, 1'b0);
    check_pulses("madam_top", 1, 0, 0, 0);
    ext_delay = 2; ext_resp = 32'h0331_0000;
    access(32'h0331_0000, 1'b0, 32'd0, 1'b1, 32'h0331_0000, 4, 1'b0);
    check_pulses("past_madam", 0, 0, 0, 0);
    check("past_madam_stb", 32'(stb_cycles), 32'd2);
    ext_delay = 1; ext_resp = 32'h0000_55AA;
    access(32'h0320_6101, 1'b0, 32'd0, 1'b1, 32'h0000_55AA, 3, 1'b0);
    clio_dout = 32'hC110_C110;
    access(32'h0340_FFFF, 1'b0, 32'd0, 1'b1, 32'hC110_C110, 4, 1'b0);
    check_pulses("clio_top", 0, 0, 1, 0);

`ifdef OPERA_BUS_TIMEOUT_EN
    // Timeout with ext_ack never arriving
    ext_auto = 1'b0;
    access(32'h0000_0200, 1'b0, 32'd0, 1'b1, 32'hDEAD_DEAD, 10, 1'b1);
    check("timeout_stb_cycles", 32'(stb_cycles), 32'd8);
    clio_dout = 32'hC110_C110;
    access(32'h0340_FFFF, 1'b0, 32'd0, 1'b1, 32'hC110_C110, 4, 1'b0);
`endif

    // Reset during a CLIO wait
    @(posedge clk_25m); #1;
    wb_adr = 32'h0340_0010; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk_25m); #1;
    reset_n = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    #1;
    check_idle_outputs("rst_abort");
    check("rst_abort_dat_r", wb_dat_r, 32'd0);
    @(negedge clk_25m); reset_n = 1'b1;
    repeat (6) @(negedge clk_25m);
    check_idle_outputs("rst_after");
    check("rst_after_dat_r", wb_dat_r, 32'd0);

    // wb_cyc dropped while waiting on the external bus
    ext_auto = 1'b0;
    @(posedge clk_25m); #1;
    clear_counts();
    wb_adr = 32'h0000_2000; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    repeat (3) @(posedge clk_25m);
    #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk_25m);
    check("cyc_drop_ext_stb", 32'(ext_stb), 32'd0);
    check("cyc_drop_stb_cycles", 32'(stb_cycles), 32'd2);
    repeat (12) @(negedge clk_25m);
    check_idle_outputs("cyc_drop_after");

    // Recovery access after both aborts
    access(32'h0320_6900, 1'b0, 32'd0, 1'b1, 32'hBADA_CCE5, 2, 1'b0);

    repeat (3) @(negedge clk_25m);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
